ctrl_decode_stage: RTL and testbench
====================================

// Module: ctrl_decode_stage
// PURPOSE
//  Registered ID stage: decodes a 32-bit RV32I instruction (optionally RV32M) into ctrl_word_struct.
//  Holds the result in a valid/ready output register between IF and EX.
//  Adds a load-use interlock, flush, illegal-instruction flagging and a saturating stall counter.
// PARAMETERS
//  EN_MEXT      1   1: decode RV32M (op_reg, funct7=7'h01); 0: such encodings are illegal
//  STALL_CNT_W  16  width of load-use stall counter
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  flush        in   1    kill held word and any incoming instruction (branch redirect)
//  in_valid     in   1    IF presents instruction
//  in_ready     out  1    stage accepts instruction this cycle (combinational)
//  in_instr     in   32   instruction word
//  in_pc        in   32   instruction PC
//  out_valid    out  1    registered decoded word valid
//  out_ready    in   1    EX accepts word
//  out_ctrl     out  $bits(ctrl_word_struct)  decoded control word
//  out_pc       out  32   PC of held word
//  out_instr    out  32   held instruction (rs1/rs2/rd/imm extraction downstream)
//  out_mext     out  1    held word is an RV32M op
//  out_mext_op  out  3    funct3 of the RV32M op (0 when out_mext=0)
//  out_illegal  out  1    held word is an illegal encoding
//  stall_cnt    out  STALL_CNT_W  saturating count of load-use bubble cycles
// BEHAVIOUR
//  Reset: out_valid=0, out_ctrl=defaults, out_pc=0, out_instr=0, out_mext=0, out_mext_op=0,
//   out_illegal=0, stall_cnt=0. in_ready=0 while rst is high.
//  Defaults: regfile_ld=0, alumux1=rs1_out, alumux2=i_imm, cmpmux=rs2_out, regfilemux=alu_out,
//   dcache_read=0, dcache_write=0, aluop=alu_add, cmpop=beq.
//  Decode: lui/auipc/jal/jalr/br/load/store/op_imm follow the RV32I control mapping.
//   op_reg slt/sltu use cmpmux=rs2_out.
//   op_imm funct3=sr: funct7[5] selects alu_sra/alu_srl.
//   op_reg add/sub and sr: funct7[5] selects the variant.
//  Illegal: unknown opcode; op_reg funct7 not in {00,20} (01 allowed iff EN_MEXT);
//   funct7=20 with op_reg funct3 not in {add,sr}; slli funct7!=00; srli/srai funct7 not in {00,20};
//   load funct3 in {3,6,7}; store funct3>2; jalr funct3!=0; br funct3 in {2,3}.
//   Illegal word: ctrl=defaults (no regfile_ld, no dcache), out_illegal=1, out_valid=1.
//  RV32M: ctrl has regfile_ld=1, alumux2=rs2_out, regfilemux=alu_out, out_mext=1, out_mext_op=funct3.
//  Latency: 1 cycle; accepted at edge N, visible at out_* after edge N.
//  Handshake: hold = out_valid && !out_ready; out_* stable while hold.
//   in_ready = !rst && !flush && !hold && !hazard.
//   Accept (in_valid && in_ready): out register loads decoded word, out_valid=1.
//   out_valid && out_ready with no accept: out_valid=0.
//  Load-use hazard = out_valid && out_ctrl.dcache_read && rd(out_instr)!=0 && one of:
//   - rs1(in_instr)==rd for opcodes other than lui/auipc/jal;
//   - rs2(in_instr)==rd for br/store/op_reg.
//   Hazard with out_ready=1: load leaves, out_valid=0 next cycle (one bubble).
//   Bubble cycles only: stall_cnt+=1 when in_valid && hazard && out_ready; saturates at all-ones.
//   Hazard with out_ready=0: plain hold, no count.
//  Flush (highest priority): next cycle out_valid=0 regardless of out_ready;
//   no accept in the flush cycle; stall_cnt not incremented.
//  rst mid-stream: the held word is discarded; stall_cnt clears.
// TESTING
//  rst 2 cycles, then idle -> out_valid=0, stall_cnt=0, in_ready=1.
//  addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1,
//   regfile_ld=1, aluop=alu_add, out_illegal=0.
//  lw x2,0(x1) then add x3,x2,x2, out_ready=1 -> one bubble (out_valid=0 one cycle),
//   add emitted next cycle, stall_cnt=1.
//  mul x3,x1,x2 (0x022081B3): EN_MEXT=1 -> out_mext=1, out_mext_op=0;
//   EN_MEXT=0 -> out_illegal=1, regfile_ld=0.
//  out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* unchanged;
//   stream resumes without loss or duplication.
//  flush asserted while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not accepted.
//  STALL_CNT_W=2, 5 load-use bubbles -> stall_cnt=3.

Source files
------------

// File: rtl/ctrl_decode_stage_if.sv
// Handshake bundle between IF, the registered decode stage and EX.
// The decoded control word travels as a flat 18-bit vector; its field layout is owned by ctrl_decode_stage.
interface ctrl_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_ctrl;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_mext;
    logic [2:0]  out_mext_op;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_pc, out_instr,
        input  out_mext, out_mext_op, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_pc, out_instr,
        output out_mext, out_mext_op, out_illegal
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Registered ID stage: RV32I(+M) decode into a control word held in a valid/ready register,
// with load-use interlock, flush, illegal-encoding flag and a saturating bubble counter.
module ctrl_decode_stage #(
    parameter int unsigned EN_MEXT     = 1,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    ctrl_decode_stage_if.slave     bus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    // Every field's default encoding is zero, so the default word is all-zeros.
    typedef struct packed {
        logic       regfile_ld;
        logic       alumux1;     // 0 rs1_out, 1 pc_out
        logic [2:0] alumux2;     // 0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2_out
        logic       cmpmux;      // 0 rs2_out, 1 i_imm
        logic [3:0] regfilemux;  // 0 alu_out, 1 br_en, 2 u_imm, 3 lw, 4 pc_plus4, 5 lb, 6 lbu, 7 lh, 8 lhu
        logic       dcache_read;
        logic       dcache_write;
        logic [2:0] aluop;       // 0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and
        logic [2:0] cmpop;       // branch funct3
    } ctrl_word_t;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_REG   = 7'b0110011;

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    ctrl_word_t  dec_ctrl;
    logic        dec_mext;
    logic        dec_illegal;

    assign opc = bus.in_instr[6:0];
    assign f3  = bus.in_instr[14:12];
    assign f7  = bus.in_instr[31:25];

    always_comb begin
        dec_ctrl    = '0;
        dec_mext    = 1'b0;
        dec_illegal = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec_ctrl.regfile_ld = 1'b1;
                dec_ctrl.regfilemux = 4'd2;
            end
            OPC_AUIPC: begin
                dec_ctrl.regfile_ld = 1'b1;
                dec_ctrl.alumux1    = 1'b1;
                dec_ctrl.alumux2    = 3'd1;
            end
            OPC_JAL: begin
                dec_ctrl.regfile_ld = 1'b1;
                dec_ctrl.regfilemux = 4'd4;
                dec_ctrl.alumux1    = 1'b1;
                dec_ctrl.alumux2    = 3'd4;
            end
            OPC_JALR: begin
                dec_illegal         = (f3 != 3'd0);
                dec_ctrl.regfile_ld = 1'b1;
                dec_ctrl.regfilemux = 4'd4;
            end
            OPC_BR: begin
                dec_illegal      = (f3 == 3'd2) || (f3 == 3'd3);
                dec_ctrl.alumux1 = 1'b1;
                dec_ctrl.alumux2 = 3'd2;
                dec_ctrl.cmpop   = f3;
            end
            OPC_LOAD: begin
                dec_ctrl.regfile_ld  = 1'b1;
                dec_ctrl.dcache_read = 1'b1;
                case (f3)
                    3'd0:    dec_ctrl.regfilemux = 4'd5;
                    3'd1:    dec_ctrl.regfilemux = 4'd7;
                    3'd2:    dec_ctrl.regfilemux = 4'd3;
                    3'd4:    dec_ctrl.regfilemux = 4'd6;
                    3'd5:    dec_ctrl.regfilemux = 4'd8;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_illegal           = (f3 > 3'd2);
                dec_ctrl.dcache_write = 1'b1;
                dec_ctrl.alumux2      = 3'd3;
            end
            OPC_IMM, OPC_REG: begin
                dec_ctrl.regfile_ld = 1'b1;
                if (opc == OPC_REG) begin
                    dec_ctrl.alumux2 = 3'd5;
                end
                if (opc == OPC_REG && f7 == 7'h01) begin
                    dec_mext    = (EN_MEXT != 0);
                    dec_illegal = (EN_MEXT == 0);
                end else begin
                    // funct7 legality differs between immediate and register forms
                    if (opc == OPC_REG) begin
                        dec_illegal = !((f7 == 7'h00) ||
                                        (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                    end else if (f3 == 3'd1) begin
                        dec_illegal = (f7 != 7'h00);
                    end else if (f3 == 3'd5) begin
                        dec_illegal = (f7 != 7'h00) && (f7 != 7'h20);
                    end
                    case (f3)
                        3'd0: dec_ctrl.aluop = (opc == OPC_REG && f7[5]) ? 3'd3 : 3'd0;
                        3'd2, 3'd3: begin
                            dec_ctrl.cmpop      = (f3 == 3'd2) ? 3'd4 : 3'd6;
                            dec_ctrl.cmpmux     = (opc == OPC_IMM);
                            dec_ctrl.regfilemux = 4'd1;
                        end
                        3'd5:    dec_ctrl.aluop = f7[5] ? 3'd2 : 3'd5;
                        default: dec_ctrl.aluop = f3;
                    endcase
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_ctrl = '0;
            dec_mext = 1'b0;
        end
    end

    logic        valid_q;
    ctrl_word_t  ctrl_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        mext_q;
    logic [2:0]  mext_op_q;
    logic        illegal_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] stall_d;

    logic [4:0] held_rd;
    logic       hz_rs1;
    logic       hz_rs2;
    logic       hazard;
    logic       hold;
    logic       ready_w;
    logic       accept;

    assign held_rd = instr_q[11:7];
    assign hz_rs1  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL) &&
                     (bus.in_instr[19:15] == held_rd);
    assign hz_rs2  = (opc == OPC_BR || opc == OPC_STORE || opc == OPC_REG) &&
                     (bus.in_instr[24:20] == held_rd);
    assign hazard  = valid_q && ctrl_q.dcache_read && (held_rd != 5'd0) && (hz_rs1 || hz_rs2);
    assign hold    = valid_q && !bus.out_ready;
    assign ready_w = !rst && !flush && !hold && !hazard;
    assign accept  = bus.in_valid && ready_w;

    // Only true bubble cycles count: a hazard while EX is stalled is just a hold.
    always_comb begin
        stall_d = stall_q;
        if (!flush && bus.in_valid && hazard && bus.out_ready && stall_q != STALL_MAX) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            mext_q    <= 1'b0;
            mext_op_q <= '0;
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            stall_q <= stall_d;
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q   <= 1'b1;
                ctrl_q    <= dec_ctrl;
                pc_q      <= bus.in_pc;
                instr_q   <= bus.in_instr;
                mext_q    <= dec_mext;
                mext_op_q <= dec_mext ? f3 : 3'd0;
                illegal_q <= dec_illegal;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = ready_w;
    assign bus.out_valid   = valid_q;
    assign bus.out_ctrl    = ctrl_q;
    assign bus.out_pc      = pc_q;
    assign bus.out_instr   = instr_q;
    assign bus.out_mext    = mext_q;
    assign bus.out_mext_op = mext_op_q;
    assign bus.out_illegal = illegal_q;
    assign stall_cnt       = stall_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed scenarios plus a random stream checked against a
// mnemonic-level decode model and a one-slot pipeline model. Instance b has M disabled and a 2-bit counter.
module tb_ctrl_decode_stage;
    typedef struct packed {
        logic       regfile_ld;
        logic       alumux1;
        logic [2:0] alumux2;
        logic       cmpmux;
        logic [3:0] regfilemux;
        logic       dcache_read;
        logic       dcache_write;
        logic [2:0] aluop;
        logic [2:0] cmpop;
    } tb_ctrl_t;

    typedef struct packed {
        tb_ctrl_t   ctrl;
        logic       mext;
        logic [2:0] mop;
        logic       ill;
    } exp_t;

    localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LOAD = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011, O_IMM = 7'b0010011, O_REG = 7'b0110011;

    localparam logic [31:0] I_ADDI = 32'h00500093;   // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000A103;   // lw x2,0(x1)
    localparam logic [31:0] I_LW2  = 32'h00012103;   // lw x2,0(x2)
    localparam logic [31:0] I_ADD  = 32'h002101B3;   // add x3,x2,x2
    localparam logic [31:0] I_MUL  = 32'h022081B3;   // mul x3,x1,x2
    localparam logic [31:0] I_DIVU = 32'h0220D1B3;   // divu x3,x1,x2

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic [15:0] stall_a;
    logic [1:0]  stall_b;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage_if ifa ();
    ctrl_decode_stage_if ifb ();

    ctrl_decode_stage #(.EN_MEXT(1), .STALL_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(ifa.slave), .stall_cnt(stall_a));
    ctrl_decode_stage #(.EN_MEXT(0), .STALL_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(ifb.slave), .stall_cnt(stall_b));

    // Decode model: decide legality from the encoding tables first, then map the mnemonic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit mx);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        case (op)
            O_LUI, O_AUIPC, O_JAL: ok = 1'b1;
            O_JALR:  ok = (f3 == 3'd0);
            O_BR:    ok = !(f3 inside {3'd2, 3'd3});
            O_LOAD:  ok = !(f3 inside {3'd3, 3'd6, 3'd7});
            O_STORE: ok = (f3 <= 3'd2);
            O_IMM:   ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                          (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            O_REG:   ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                          (f7 == 7'h01 && mx);
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.ill = 1'b1;
            return e;
        end
        case (op)
            O_LUI:   begin e.ctrl.regfile_ld = 1'b1; e.ctrl.regfilemux = 4'd2; end
            O_AUIPC: begin e.ctrl.regfile_ld = 1'b1; e.ctrl.alumux1 = 1'b1; e.ctrl.alumux2 = 3'd1; end
            O_JAL:   begin e.ctrl.regfile_ld = 1'b1; e.ctrl.regfilemux = 4'd4;
                           e.ctrl.alumux1 = 1'b1; e.ctrl.alumux2 = 3'd4; end
            O_JALR:  begin e.ctrl.regfile_ld = 1'b1; e.ctrl.regfilemux = 4'd4; end
            O_BR:    begin e.ctrl.alumux1 = 1'b1; e.ctrl.alumux2 = 3'd2; e.ctrl.cmpop = f3; end
            O_STORE: begin e.ctrl.dcache_write = 1'b1; e.ctrl.alumux2 = 3'd3; end
            O_LOAD: begin
                e.ctrl.regfile_ld = 1'b1;
                e.ctrl.dcache_read = 1'b1;
                e.ctrl.regfilemux = (f3 == 3'd0) ? 4'd5 : (f3 == 3'd1) ? 4'd7 :
                                    (f3 == 3'd2) ? 4'd3 : (f3 == 3'd4) ? 4'd6 : 4'd8;
            end
            default: begin
                e.ctrl.regfile_ld = 1'b1;
                if (op == O_REG) e.ctrl.alumux2 = 3'd5;
                if (op == O_REG && f7 == 7'h01) begin
                    e.mext = 1'b1;
                    e.mop = f3;
                end else if (f3 == 3'd2 || f3 == 3'd3) begin
                    e.ctrl.regfilemux = 4'd1;
                    e.ctrl.cmpop = (f3 == 3'd2) ? 3'd4 : 3'd6;
                    e.ctrl.cmpmux = (op == O_IMM);
                end else if (f3 == 3'd0) begin
                    e.ctrl.aluop = (op == O_REG && f7 == 7'h20) ? 3'd3 : 3'd0;
                end else if (f3 == 3'd5) begin
                    e.ctrl.aluop = (f7 == 7'h20) ? 3'd2 : 3'd5;
                end else begin
                    e.ctrl.aluop = f3;
                end
            end
        endcase
        return e;
    endfunction

    function automatic bit reads_rs1(input logic [31:0] ins);
        return !(ins[6:0] inside {O_LUI, O_AUIPC, O_JAL});
    endfunction

    function automatic bit reads_rs2(input logic [31:0] ins);
        return ins[6:0] inside {O_BR, O_STORE, O_REG};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: w[6:0] = O_LUI;   1: w[6:0] = O_AUIPC; 2: w[6:0] = O_JAL;
            3: w[6:0] = O_JALR;  4: w[6:0] = O_BR;    5, 6: w[6:0] = O_LOAD;
            7: w[6:0] = O_STORE; 8: w[6:0] = O_IMM;   9, 10: w[6:0] = O_REG;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 4);
        if (k < 2) w[31:25] = 7'h00;
        else if (k == 2) w[31:25] = 7'h20;
        else if (k == 3) w[31:25] = 7'h01;
        return w;
    endfunction

    task automatic idle_inputs();
        ifa.in_valid = 1'b0; ifa.in_instr = '0; ifa.in_pc = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_instr = '0; ifb.in_pc = '0; ifb.out_ready = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", ifa.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ifa.out_valid); end
        n_checks++;
        if (stall_a !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_a); end
        n_checks++;
        if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", ifa.in_ready); end
        n_checks++;
        if ({ifa.out_ctrl, ifa.out_pc, ifa.out_instr, ifa.out_mext, ifa.out_mext_op, ifa.out_illegal} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ctrl %h pc %h instr %h mext %b op %0d ill %b want all 0",
                     ifa.out_ctrl, ifa.out_pc, ifa.out_instr, ifa.out_mext, ifa.out_mext_op, ifa.out_illegal);
        end
    endtask

    task automatic test_addi();
        exp_t e;
        e = ref_decode(I_ADDI, 1'b1);
        ifa.in_valid = 1'b1; ifa.in_instr = I_ADDI; ifa.in_pc = 32'h100;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        n_checks++;
        if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", ifa.out_valid); end
        n_checks++;
        if (ifa.out_ctrl[17] !== 1'b1 || ifa.out_ctrl[5:3] !== 3'd0 || ifa.out_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_fields: ld %b aluop %0d ill %b want 1 0 0", ifa.out_ctrl[17], ifa.out_ctrl[5:3], ifa.out_illegal);
        end
        n_checks++;
        if (ifa.out_ctrl !== e.ctrl || ifa.out_pc !== 32'h100) begin
            n_fail++; $display("FAIL addi_word: ctrl %h pc %h want %h 100", ifa.out_ctrl, ifa.out_pc, e.ctrl);
        end
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", ifa.out_valid); end
    endtask

    task automatic test_load_use();
        do_reset();
        ifa.in_valid = 1'b1; ifa.in_instr = I_LW; ifa.in_pc = 32'h200;
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_ctrl[7] !== 1'b1) begin
            n_fail++; $display("FAIL lu_load_held: valid %b dread %b want 1 1", ifa.out_valid, ifa.out_ctrl[7]);
        end
        ifa.in_instr = I_ADD; ifa.in_pc = 32'h204;
        #1;
        n_checks++;
        if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_interlock: in_ready %b want 0", ifa.in_ready); end
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0 || stall_a !== 16'd1) begin
            n_fail++; $display("FAIL lu_bubble: valid %b stall %0d want 0 1", ifa.out_valid, stall_a);
        end
        @(negedge clk);
        ifa.in_valid = 1'b0;
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_instr !== I_ADD || ifa.out_pc !== 32'h204 || stall_a !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_add_out: valid %b instr %h pc %h stall %0d want 1 %h 204 1",
                     ifa.out_valid, ifa.out_instr, ifa.out_pc, stall_a, I_ADD);
        end
        @(negedge clk);
    endtask

    task automatic test_mext();
        logic [31:0] ops [2];
        exp_t e;
        ops[0] = I_MUL; ops[1] = I_DIVU;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = ref_decode(ops[i], 1'b1);
            ifa.in_valid = 1'b1; ifa.in_instr = ops[i];
            ifb.in_valid = 1'b1; ifb.in_instr = ops[i];
            @(negedge clk);
            ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
            n_checks++;
            if (ifa.out_mext !== 1'b1 || ifa.out_mext_op !== ops[i][14:12] || ifa.out_illegal !== 1'b0 ||
                ifa.out_ctrl !== e.ctrl) begin
                n_fail++;
                $display("FAIL mext_on[%0d]: mext %b op %0d ill %b ctrl %h want 1 %0d 0 %h",
                         i, ifa.out_mext, ifa.out_mext_op, ifa.out_illegal, ifa.out_ctrl, ops[i][14:12], e.ctrl);
            end
            n_checks++;
            if (ifb.out_valid !== 1'b1 || ifb.out_illegal !== 1'b1 || ifb.out_ctrl !== 18'd0 || ifb.out_mext !== 1'b0) begin
                n_fail++;
                $display("FAIL mext_off[%0d]: valid %b ill %b ctrl %h mext %b want 1 1 0 0",
                         i, ifb.out_valid, ifb.out_illegal, ifb.out_ctrl, ifb.out_mext);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        logic [31:0] seq [3];
        seq[0] = 32'h00100093; seq[1] = 32'h00200113; seq[2] = 32'h00300193;
        do_reset();
        ifa.in_valid = 1'b1; ifa.in_instr = seq[0]; ifa.in_pc = 32'h300;
        @(negedge clk);
        ifa.out_ready = 1'b0; ifa.in_instr = seq[1]; ifa.in_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 0", k, ifa.in_ready); end
            @(negedge clk);
            n_checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_instr !== seq[0] || ifa.out_pc !== 32'h300) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: valid %b instr %h pc %h want 1 %h 300", k, ifa.out_valid, ifa.out_instr, ifa.out_pc, seq[0]);
            end
        end
        ifa.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_instr !== seq[1]) begin
            n_fail++; $display("FAIL hold_resume1: valid %b instr %h want 1 %h", ifa.out_valid, ifa.out_instr, seq[1]);
        end
        ifa.in_instr = seq[2]; ifa.in_pc = 32'h308;
        @(negedge clk);
        ifa.in_valid = 1'b0;
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_instr !== seq[2]) begin
            n_fail++; $display("FAIL hold_resume2: valid %b instr %h want 1 %h", ifa.out_valid, ifa.out_instr, seq[2]);
        end
        @(negedge clk);
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_nodup: valid %b want 0", ifa.out_valid); end
    endtask

    task automatic test_flush();
        logic [15:0] s0;
        do_reset();
        ifa.in_valid = 1'b1; ifa.in_instr = I_ADDI;
        @(negedge clk);
        ifa.in_instr = 32'h00200113; ifa.out_ready = 1'b0; flush_a = 1'b1;
        #1;
        n_checks++;
        if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", ifa.in_ready); end
        @(negedge clk);
        flush_a = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_kill: valid %b want 0", ifa.out_valid); end
        // a load-use pair under flush must not count a bubble
        s0 = stall_a;
        ifa.in_valid = 1'b1; ifa.in_instr = I_LW;
        @(negedge clk);
        ifa.in_instr = I_ADD; flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0; ifa.in_valid = 1'b0;
        n_checks++;
        if (ifa.out_valid !== 1'b0 || stall_a !== s0) begin
            n_fail++; $display("FAIL flush_nocount: valid %b stall %0d want 0 %0d", ifa.out_valid, stall_a, s0);
        end
    endtask

    task automatic test_stall_sat();
        bit ok;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            ifb.in_valid = 1'b1; ifb.in_instr = (n == 0) ? I_LW : I_LW2;
            ok = 1'b0;
            for (int c = 0; c < 10 && !ok; c++) begin
                #1;
                ok = ifb.in_ready;
                @(negedge clk);
            end
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL sat_timeout[%0d]: in_ready %b want 1 within 10 cycles", n, ifb.in_ready); end
        end
        ifb.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (stall_b !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d want 3", stall_b); end
    endtask

    task automatic test_random();
        bit m_valid;
        logic [31:0] m_instr, m_pc, ins, pc;
        logic [15:0] m_stall;
        bit v, ordy, dep, exp_rdy;
        exp_t e, eh;
        do_reset();
        m_valid = 1'b0; m_instr = '0; m_pc = '0; m_stall = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if (ifa.out_valid !== m_valid || stall_a !== m_stall) begin
                n_fail++; $display("FAIL rnd_state@%0d: valid %b stall %0d want %b %0d", cyc, ifa.out_valid, stall_a, m_valid, m_stall);
            end
            if (m_valid) begin
                e = ref_decode(m_instr, 1'b1);
                n_checks++;
                if (ifa.out_instr !== m_instr || ifa.out_pc !== m_pc || ifa.out_ctrl !== e.ctrl ||
                    ifa.out_mext !== e.mext || ifa.out_mext_op !== e.mop || ifa.out_illegal !== e.ill) begin
                    n_fail++;
                    $display("FAIL rnd_word@%0d: instr %h pc %h ctrl %h m %b op %0d ill %b want %h %h %h %b %0d %b",
                             cyc, ifa.out_instr, ifa.out_pc, ifa.out_ctrl, ifa.out_mext, ifa.out_mext_op, ifa.out_illegal,
                             m_instr, m_pc, e.ctrl, e.mext, e.mop, e.ill);
                end
            end
            v = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            ins = gen_instr();
            pc = $urandom;
            ifa.in_valid = v; ifa.in_instr = ins; ifa.in_pc = pc; ifa.out_ready = ordy;
            #1;
            eh = ref_decode(m_instr, 1'b1);
            dep = m_valid && eh.ctrl.dcache_read && (m_instr[11:7] != 5'd0) &&
                  ((reads_rs1(ins) && ins[19:15] == m_instr[11:7]) || (reads_rs2(ins) && ins[24:20] == m_instr[11:7]));
            exp_rdy = !(m_valid && !ordy) && !dep;
            n_checks++;
            if (ifa.in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b (instr %h held %h)", cyc, ifa.in_ready, exp_rdy, ins, m_instr);
            end
            if (v && dep && ordy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (v && exp_rdy) begin
                m_valid = 1'b1; m_instr = ins; m_pc = pc;
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
            @(negedge clk);
        end
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_addi();
        test_load_use();
        test_mext();
        test_hold();
        test_flush();
        test_stall_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
